// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: architectural widths, index/data types and
// the write-hit helper used by the register file read ports.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_GPRS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;

  // True when this cycle's writeback targets the register being read.
  // wr_idx/wr_data are ignored while wr_en is low.
  function automatic logic write_hits(input logic wr_en, input reg_idx_t wr_idx,
                                      input reg_idx_t rd_idx);
    return wr_en && (wr_idx == rd_idx);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 forces zero, otherwise the in-flight
// writeback value wins over the stored value (WB->ID write-through).
module regfile_read_port
  import riscv_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rd_idx,
  input  logic [XLEN-1:0]      stored_data,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [XLEN-1:0]      wr_data,
  output logic [XLEN-1:0]      rd_data
);

  // zero / bypass / storage select
  always_comb begin
    rd_data = {XLEN{1'b0}};
    if (rd_idx == {REG_IDX_W{1'b0}}) begin
      rd_data = {XLEN{1'b0}};
    end else if (write_hits(wr_en, wr_idx, rd_idx)) begin
      rd_data = wr_data;
    end else begin
      rd_data = stored_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: 32 x 32-bit GPRs, two combinational read
// ports with write-through bypass, one synchronous write port, x0 hardwired.
module register_file
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned NUM_REGS   = NUM_GPRS,
  parameter int unsigned IDX_WIDTH  = REG_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_WIDTH-1:0]  r1_idx,
  input  logic [IDX_WIDTH-1:0]  r2_idx,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] reg1_data,
  output logic [DATA_WIDTH-1:0] reg2_data
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // next-state: single write port, x0 writes dropped; reset handled in the flop
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_idx != {IDX_WIDTH{1'b0}})) begin
      regs_d[wr_idx] = wr_data;
    end else begin
      regs_d = regs_q;
    end
    regs_d[0] = {DATA_WIDTH{1'b0}};
  end

  // storage update; rst_n is an active-high synchronous clear that beats a write
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port u_rd1 (
    .rd_idx      (r1_idx),
    .stored_data (regs_q[r1_idx]),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .rd_data     (reg1_data)
  );

  regfile_read_port u_rd2 (
    .rd_idx      (r2_idx),
    .stored_data (regs_q[r2_idx]),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .rd_data     (reg2_data)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file: each row is applied after
// the falling edge, outputs are checked before the next rising edge.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  r1_idx, r2_idx, wr_idx;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] reg1_data, reg2_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  widx;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [18];

  register_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r1_idx    (r1_idx),
    .r2_idx    (r2_idx),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .reg1_data (reg1_data),
    .reg2_data (reg2_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    // rst, we, widx, wdata, r1, r2, exp1, exp2 (exp = value before the rising edge)
    vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'hAAAAAAAA, 5'd5,  5'd0,  32'hAAAAAAAA, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b0, 5'd5,  32'h0BADF00D, 5'd5,  5'd5,  32'hAAAAAAAA, 32'hAAAAAAAA};
    vecs[2]  = '{1'b0, 1'b1, 5'd10, 32'hDEADBEEF, 5'd10, 5'd10, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b0, 5'd10, 32'h00000000, 5'd10, 5'd10, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h00000000, 32'hAAAAAAAA};
    vecs[6]  = '{1'b0, 1'b1, 5'd3,  32'h11111111, 5'd3,  5'd4,  32'h11111111, 32'h00000000};
    vecs[7]  = '{1'b0, 1'b1, 5'd4,  32'h22222222, 5'd3,  5'd4,  32'h11111111, 32'h22222222};
    vecs[8]  = '{1'b0, 1'b0, 5'd3,  32'h99999999, 5'd3,  5'd4,  32'h11111111, 32'h22222222};
    vecs[9]  = '{1'b0, 1'b1, 5'd3,  32'h33333333, 5'd3,  5'd10, 32'h33333333, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 1'b0, 5'd3,  32'h44444444, 5'd3,  5'd3,  32'h33333333, 32'h33333333};
    vecs[11] = '{1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h00000000};
    vecs[12] = '{1'b0, 1'b0, 5'd31, 32'h12121212, 5'd31, 5'd1,  32'hCAFEF00D, 32'h00000000};
    // reset with a concurrent write: bypass still visible, storage cleared, write lost
    vecs[13] = '{1'b1, 1'b1, 5'd7,  32'h12345678, 5'd7,  5'd5,  32'h12345678, 32'hAAAAAAAA};
    vecs[14] = '{1'b0, 1'b0, 5'd7,  32'h12345678, 5'd7,  5'd5,  32'h00000000, 32'h00000000};
    vecs[15] = '{1'b0, 1'b0, 5'd0,  32'h00000000, 5'd3,  5'd31, 32'h00000000, 32'h00000000};
    vecs[16] = '{1'b0, 1'b1, 5'd1,  32'h5A5A5A5A, 5'd4,  5'd10, 32'h00000000, 32'h00000000};
    vecs[17] = '{1'b0, 1'b0, 5'd2,  32'hFFFFFFFF, 5'd1,  5'd2,  32'h5A5A5A5A, 32'h00000000};

    rst_n = 1'b1; wr_en = 1'b0; wr_idx = 5'd0; wr_data = 32'h0;
    r1_idx = 5'd0; r2_idx = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;

    // every register reads zero after reset, both ports
    for (int i = 1; i < 32; i++) begin
      r1_idx = 5'(i);
      r2_idx = 5'(32 - i);
      #1;
      check($sformatf("reset_r1_x%0d", i), reg1_data, 32'h00000000);
      check($sformatf("reset_r2_x%0d", 32 - i), reg2_data, 32'h00000000);
    end

    for (int v = 0; v < 18; v++) begin
      @(negedge clk);
      rst_n   = vecs[v].rst;
      wr_en   = vecs[v].we;
      wr_idx  = vecs[v].widx;
      wr_data = vecs[v].wdata;
      r1_idx  = vecs[v].r1;
      r2_idx  = vecs[v].r2;
      #1;
      check($sformatf("vec%0d_r1", v), reg1_data, vecs[v].exp1);
      check($sformatf("vec%0d_r2", v), reg2_data, vecs[v].exp2);
    end

    // x0 write attempt: zero before and after the edge
    @(negedge clk);
    rst_n = 1'b0; wr_en = 1'b1; wr_idx = 5'd0; wr_data = 32'hFFFFFFFF;
    r1_idx = 5'd0; r2_idx = 5'd0;
    #1;
    check("x0_before_edge", reg1_data, 32'h00000000);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("x0_after_edge", reg1_data, 32'h00000000);

    // back-to-back writes to one register: latest value wins, then storage holds it
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 5'd9; wr_data = 32'h01010101; r1_idx = 5'd9; r2_idx = 5'd9;
    #1;
    check("b2b_first_bypass", reg1_data, 32'h01010101);
    @(negedge clk);
    wr_data = 32'h02020202;
    #1;
    check("b2b_second_bypass", reg2_data, 32'h02020202);
    @(negedge clk);
    wr_en = 1'b0; wr_data = 32'h77777777;
    #1;
    check("b2b_stored_r1", reg1_data, 32'h02020202);
    check("b2b_stored_r2", reg2_data, 32'h02020202);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
